// File: rtl/mips16_pkg.sv
// ---------------------------------------------------------------------------
// mips16_pkg
// Shared types and constants for the mips16 result-streaming logic.
//   tx_state_t      : UART transmitter FSM states
//   UART_START_BIT  : line level of a start bit
//   UART_STOP_BIT   : line level of a stop bit (also the idle level)
//   BITS_PER_BYTE   : data bits per 8N1 frame
//   RESULT_W        : width of one CPU result word
// ---------------------------------------------------------------------------
package mips16_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam logic UART_START_BIT = 1'b0;
    localparam logic UART_STOP_BIT  = 1'b1;
    localparam int   BITS_PER_BYTE  = 8;
    localparam int   RESULT_W       = 16;

endpackage

// File: rtl/result_fifo.sv
// ---------------------------------------------------------------------------
// result_fifo
// Small synchronous FIFO used to buffer CPU result words ahead of the UART.
//   clk, rst   : clock, synchronous active-high reset
//   push       : write push_data (ignored while full)
//   push_data  : word to store
//   pop        : remove the head word (ignored while empty)
//   pop_data   : current head word, valid whenever empty is low
//   full/empty : status, derived from the registered count only
//   count      : number of words buffered (0..FIFO_DEPTH)
// ---------------------------------------------------------------------------
module result_fifo #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [DATA_W-1:0]             push_data,
    input  logic                          pop,
    output logic [DATA_W-1:0]             pop_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push_ok;
    logic              pop_ok;

    assign full     = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    // Head is read combinationally so a word written at one edge can be
    // popped at the very next edge (cut-through into an idle transmitter).
    assign pop_data = mem_q[rd_ptr_q];

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Depth is a power of two, so pointers wrap naturally.
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage carries no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/alu_result_uart_tx.sv
// ---------------------------------------------------------------------------
// alu_result_uart_tx
// Captures 16-bit CPU results into a FIFO and streams each word over a UART
// line as two 8N1 frames, low byte first.
//   clk, rst   : clock, synchronous active-high reset
//   res_valid  : result word present this cycle
//   res_data   : result word
//   res_ready  : FIFO not full; a word is accepted iff res_valid && res_ready
//   tx         : registered UART serial output, idle high
//   busy       : transmitter not idle
//   fifo_count : words currently buffered
//   overflow   : sticky, a word was offered while full and dropped
// ---------------------------------------------------------------------------
module alu_result_uart_tx
    import mips16_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4,
    parameter int DATA_W       = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          res_valid,
    input  logic [DATA_W-1:0]             res_data,
    output logic                          res_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(BITS_PER_BYTE);

    logic [RESULT_W-1:0] fifo_head;
    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_pop;

    tx_state_t           state_q, state_d;
    logic [BAUD_W-1:0]   baud_q, baud_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic                byte_sel_q, byte_sel_d;
    logic [RESULT_W-1:0] hold_q, hold_d;
    logic                tx_q, tx_d;
    logic                overflow_q, overflow_d;

    logic                baud_end;
    logic [7:0]          cur_byte;

    result_fifo #(
        .DATA_W     (RESULT_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (res_valid),
        .push_data (res_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign res_ready = !fifo_full;
    assign busy      = (state_q != IDLE);
    assign tx        = tx_q;
    assign overflow  = overflow_q;
    assign baud_end  = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        byte_sel_d = byte_sel_q;
        hold_d     = hold_q;
        fifo_pop   = 1'b0;
        overflow_d = overflow_q | (res_valid & fifo_full);

        if (state_q == IDLE) begin
            baud_d = '0;
        end else begin
            baud_d = baud_end ? '0 : baud_q + BAUD_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    hold_d     = fifo_head;
                    byte_sel_d = 1'b0;
                    state_d    = START;
                end
            end
            START: begin
                if (baud_end) begin
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (baud_end) begin
                    if (bit_q == BIT_W'(BITS_PER_BYTE - 1)) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            STOP: begin
                if (baud_end) begin
                    if (!byte_sel_q) begin
                        byte_sel_d = 1'b1;
                        state_d    = START;
                    end else if (!fifo_empty) begin
                        // Chain straight into the next word with no idle gap.
                        fifo_pop   = 1'b1;
                        hold_d     = fifo_head;
                        byte_sel_d = 1'b0;
                        state_d    = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // tx is produced from the next-state values so the line level is
        // registered and lines up exactly with the state it belongs to.
        cur_byte = byte_sel_d ? hold_d[15:8] : hold_d[7:0];
        case (state_d)
            START:   tx_d = UART_START_BIT;
            DATA:    tx_d = cur_byte[bit_d];
            default: tx_d = UART_STOP_BIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            byte_sel_q <= 1'b0;
            hold_q     <= '0;
            tx_q       <= UART_STOP_BIT;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            byte_sel_q <= byte_sel_d;
            hold_q     <= hold_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_d;
        end
    end

endmodule
